microwire_ctl: RTL
==================

MICROWIRE_CTL -- requirements
Module: microwire_ctl

Interface
REQ-001 Parameter ADDR_W, default 6: EEPROM address width in bits.
REQ-002 Parameter DATA_W, default 16: EEPROM word width in bits.
REQ-003 Parameter CLK_DIV, default 4: clk cycles per SK half-period; legal range 1..255.
REQ-004 Parameter TIMEOUT_CYC, default 100000: maximum number of poll cycles allowed for a busy wait.
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-low, with ports named clk and rst_n.
REQ-006 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  async active-low reset.
- req_valid  in  1  host command valid.
- req_ready  out  1  controller can accept a command.
- req_op  in  3  000 READ, 001 WRITE, 010 ERASE, 011 EWEN, 100 EWDS.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, held until the next READ completes.
- rsp_err  out  1  qualified by rsp_valid: timeout or illegal op.
- ee_cs  out  1  chip select, active high.
- ee_sk  out  1  serial clock.
- ee_di  out  1  serial data to the EEPROM.
- ee_do  in  1  serial data from the EEPROM (ready/busy during polls).

Function
REQ-007 The state machine SHALL have the states IDLE, CMD, RDATA, WDATA, CSLOW, POLL and RESP.
REQ-008 req_ready SHALL be 1 only in IDLE; a command SHALL be accepted on the rising edge where req_valid=1 and req_ready=1, and req_op/req_addr/req_wdata SHALL be latched at that edge.
REQ-009 On an accepted legal op, the block SHALL enter CMD and raise ee_cs at the next edge.
REQ-010 Each bit period SHALL be 2*CLK_DIV clocks: ee_sk low for the first CLK_DIV clocks, then high for CLK_DIV clocks.
REQ-011 ee_di SHALL change only at the start of a bit period, while ee_sk is low.
REQ-012 ee_do SHALL be sampled on the clk edge where ee_sk rises.
REQ-013 CMD SHALL shift 3+ADDR_W bits, MSB first:
- start bit 1;
- opcode: READ 10, WRITE 01, ERASE 11, EWEN/EWDS 00;
- address: req_addr for READ/WRITE/ERASE; for EWEN, 11 followed by zeros; for EWDS, all zeros.
REQ-014 After CMD the next state SHALL be:
- READ -> RDATA;
- WRITE -> WDATA;
- ERASE, EWEN, EWDS -> CSLOW.
REQ-015 RDATA SHALL run DATA_W bit periods, shifting ee_do MSB first into the read register; ee_di SHALL be 0 during RDATA.
REQ-016 WDATA SHALL shift req_wdata MSB first over DATA_W bit periods.
REQ-017 CSLOW SHALL hold ee_cs=0 and ee_sk=0 for 2*CLK_DIV clocks.
REQ-018 After CSLOW:
- READ, EWEN and EWDS SHALL go to RESP;
- WRITE and ERASE SHALL go to POLL.
REQ-019 POLL SHALL hold ee_cs=1 and ee_sk=0 and sample ee_do every clk.
REQ-020 In POLL, the first sample with ee_do=1 SHALL drop ee_cs and go to RESP with rsp_err=0.
REQ-021 In POLL, if TIMEOUT_CYC samples are all 0, the block SHALL drop ee_cs and go to RESP with rsp_err=1.
REQ-022 RESP SHALL assert rsp_valid for exactly one cycle and then return to IDLE; rsp_valid has no backpressure.
REQ-023 rsp_rdata SHALL update only at the RESP of a READ.
REQ-024 For an illegal req_op (101-111), the command SHALL be accepted, there SHALL be no bus activity (ee_cs stays 0), and rsp_valid=1 with rsp_err=1 SHALL appear on the cycle after acceptance.
REQ-025 Outside CMD/RDATA/WDATA, ee_sk SHALL be 0; outside CMD/WDATA, ee_di SHALL be 0.
REQ-026 The bit counter and divider SHALL be sized for max(3+ADDR_W, DATA_W) and CLK_DIV respectively, with no wrap within a phase.

Reset
REQ-027 While rst_n=0, all outputs SHALL be 0 except req_ready; the state SHALL be IDLE and rsp_rdata SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL drop ee_cs immediately (asynchronously) and produce no rsp_valid for the aborted command.
REQ-029 req_ready SHALL be 1 from the first clk edge after rst_n deasserts.

Verification
REQ-030 The bench SHALL cover these directed scenarios (CLK_DIV=2, ADDR_W=6, DATA_W=16 unless stated):
- READ addr 0x15, model drives 0xA5C3 -> di bits 1,10,010101; rsp_rdata=0xA5C3; ee_cs high for 100 clocks; rsp_valid 4 clocks after ee_cs falls.
- WRITE addr 0x3F data 0x1234, model busy for 50 clocks -> di 1,01,111111 then 0x1234 MSB first; rsp_err=0 after ready.
- ERASE with ee_do stuck 0, TIMEOUT_CYC=20 -> rsp_valid with rsp_err=1 after 20 poll clocks; ee_cs=0.
- EWEN then EWDS -> di 1,00,110000 then 1,00,000000; no POLL state; two rsp_valid pulses.
- req_op=110 -> rsp_err=1 the next cycle; ee_cs never rises.
- rst_n low during WDATA bit 7 -> ee_cs=0 at once; no rsp_valid; a following READ completes normally.

Source files
------------

// File: rtl/microwire_ctl.sv
// Microwire (93Cxx-style) serial EEPROM controller: one host command in, one
// framed bus transaction out, with ready/busy polling after WRITE and ERASE.
//
// state | meaning
// IDLE  | waiting for a host command, req_ready high
// CMD   | shifting start bit, opcode and address
// RDATA | clocking DATA_W bits in from ee_do
// WDATA | shifting write data out on ee_di
// CSLOW | chip select low gap between frame and poll/response
// POLL  | chip select high, sampling ee_do for ready
// RESP  | one-cycle rsp_valid pulse
module microwire_ctl #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int CLK_DIV     = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ee_cs,
  output logic              ee_sk,
  output logic              ee_di,
  input  logic              ee_do
);

  typedef enum logic [2:0] {IDLE, CMD, RDATA, WDATA, CSLOW, POLL, RESP} state_t;

  localparam int CMD_W   = 3 + ADDR_W;
  localparam int BIT_MAX = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int BIT_W   = $clog2(BIT_MAX + 1);
  localparam int DIV_W   = $clog2(2 * CLK_DIV);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] CSLOW_LOAD = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] CMD_LAST   = BIT_W'(CMD_W - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_LOAD    = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_ERASE = 3'd2;
  localparam logic [2:0] OP_EWEN  = 3'd3;

  state_t            state;
  logic [2:0]        op_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [TO_W-1:0]   poll_cnt;
  logic [CMD_W-1:0]  cmd_sr;
  logic [DATA_W-1:0] wd_sr;
  logic [DATA_W-1:0] rd_sr;
  logic [CMD_W-1:0]  cmd_word;
  logic [ADDR_W-1:0] ewen_addr;
  logic              legal;
  logic              tick;

  assign req_ready = (state == IDLE);
  assign tick      = (div_cnt == '0);

  always_comb begin
    legal     = (req_op <= 3'd4);
    ewen_addr = '0;
    ewen_addr[ADDR_W-1 -: 2] = 2'b11;
    case (req_op)
      3'd0:    cmd_word = {3'b110, req_addr};
      3'd1:    cmd_word = {3'b101, req_addr};
      3'd2:    cmd_word = {3'b111, req_addr};
      3'd3:    cmd_word = {3'b100, ewen_addr};
      default: cmd_word = {3'b100, {ADDR_W{1'b0}}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      poll_cnt  <= '0;
      cmd_sr    <= '0;
      wd_sr     <= '0;
      rd_sr     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      ee_cs     <= 1'b0;
      ee_sk     <= 1'b0;
      ee_di     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            wd_sr <= req_wdata;
            if (legal) begin
              state   <= CMD;
              ee_cs   <= 1'b1;
              ee_sk   <= 1'b0;
              ee_di   <= cmd_word[CMD_W-1];
              cmd_sr  <= cmd_word << 1;
              div_cnt <= DIV_LOAD;
              bit_cnt <= CMD_LAST;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        CMD, RDATA, WDATA: begin
          if (!tick) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LOAD;
            ee_sk   <= ~ee_sk;
            if (!ee_sk) begin
              // rising SK: the EEPROM's data is valid here
              if (state == RDATA) rd_sr <= {rd_sr[DATA_W-2:0], ee_do};
            end else if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              if (state == CMD) begin
                ee_di  <= cmd_sr[CMD_W-1];
                cmd_sr <= cmd_sr << 1;
              end else if (state == WDATA) begin
                ee_di <= wd_sr[DATA_W-1];
                wd_sr <= wd_sr << 1;
              end
            end else if (state == CMD && op_q == OP_READ) begin
              state   <= RDATA;
              bit_cnt <= DATA_LAST;
              ee_di   <= 1'b0;
            end else if (state == CMD && op_q == OP_WRITE) begin
              state   <= WDATA;
              bit_cnt <= DATA_LAST;
              ee_di   <= wd_sr[DATA_W-1];
              wd_sr   <= wd_sr << 1;
            end else begin
              state   <= CSLOW;
              ee_cs   <= 1'b0;
              ee_di   <= 1'b0;
              div_cnt <= CSLOW_LOAD;
            end
          end
        end
        CSLOW: begin
          if (!tick) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (op_q == OP_WRITE || op_q == OP_ERASE) begin
            state    <= POLL;
            ee_cs    <= 1'b1;
            poll_cnt <= TO_LOAD;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            if (op_q == OP_READ) rsp_rdata <= rd_sr;
          end
        end
        POLL: begin
          if (ee_do || poll_cnt == '0) begin
            state     <= RESP;
            ee_cs     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= ~ee_do;
          end else begin
            poll_cnt <= poll_cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
